// File: rtl/pkg_ili9341.sv
// Shared types and constants for the ILI9341 command path.
package pkg_ili9341;

    localparam logic HIGH    = 1'b1;
    localparam logic LOW     = 1'b0;
    // Value parked on the data bus whenever no byte is being offered.
    localparam int   NO_DATA = 0;

    // Entry layout for the standard 8-bit data / 16-bit delay tables.
    localparam int CMD_DW    = 8;
    localparam int CMD_DLY_W = 16;

    typedef struct packed {
        logic [CMD_DLY_W-1:0] dly;
        logic                 cs;
        logic                 dc;
        logic [CMD_DW-1:0]    data;
    } cmd_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_GAP,
        S_DELAY,
        S_NEXT,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/wait_timer.sv
// Loadable wait: counts `units` passes of a LEN-cycle unit counter.
// busy is high for exactly units*LEN cycles after load; expire marks the last one.
module wait_timer #(
    parameter int UW  = 16,
    parameter int LEN = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [UW-1:0] units,
    output logic          busy,
    output logic          expire
);

    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    logic [CW-1:0] unit_cnt;
    logic [UW-1:0] units_left;
    logic          last_cycle;

    assign last_cycle = (unit_cnt == CW'(LEN - 1));
    assign expire     = busy && last_cycle && (units_left == UW'(1));

    // Unit counter wraps at LEN-1 and steps the unit down-counter; a zero load never starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= 1'b0;
            unit_cnt   <= '0;
            units_left <= '0;
        end else if (load) begin
            busy       <= (units != '0);
            unit_cnt   <= '0;
            units_left <= units;
        end else if (busy && last_cycle) begin
            unit_cnt   <= '0;
            units_left <= units_left - UW'(1);
            if (units_left == UW'(1))
                busy <= 1'b0;
        end else if (busy) begin
            unit_cnt <= unit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Walks one ROM command table, handing each entry to the byte serializer,
// then holding CS/DC for a fixed gap and an optional per-entry post-delay.
module cmd_sequencer
    import pkg_ili9341::*;
#(
    parameter int DW       = 8,
    parameter int N_TABLES = 2,
    parameter int DEPTH    = 64,
    parameter int DLY_W    = 16,
    parameter int DLY_UNIT = 1000,
    parameter int GAP      = 8,
    localparam int SW      = (N_TABLES > 1) ? $clog2(N_TABLES) : 1,
    localparam int AW      = $clog2(DEPTH + 1),
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int RW      = DW + 2 + DLY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [SW-1:0]    i_sel,
    input  logic [AW-1:0]    i_len,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [SW+IW-1:0] o_rd_addr,
    input  logic [RW-1:0]    i_rd_data,
    output logic             o_send,
    input  logic             i_sent,
    output logic [DW-1:0]    o_data,
    output logic             o_dc,
    output logic             o_cs
);

    typedef struct packed {
        logic [DLY_W-1:0] dly;
        logic             cs;
        logic             dc;
        logic [DW-1:0]    data;
    } entry_t;

    seq_state_t    state;
    logic [SW-1:0] sel_q;
    logic [AW-1:0] len_q;
    logic [IW-1:0] idx;
    entry_t        entry;
    entry_t        rd_entry;

    logic gap_load, gap_busy, gap_expire, gap_done;
    logic dly_load, dly_busy, dly_expire, dly_done;

    assign rd_entry = i_rd_data;

    // Timers are loaded on the edge that enters their state so the state lasts exactly the count.
    assign gap_load = (state == S_SEND) && i_sent && !i_abort;
    assign gap_done = gap_expire || !gap_busy;
    assign dly_load = (state == S_GAP) && gap_done && (entry.dly != '0) && !i_abort;
    assign dly_done = dly_expire || !dly_busy;

    wait_timer #(.UW(1), .LEN(GAP)) u_gap (
        .clk    (clk),
        .rst    (rst),
        .load   (gap_load),
        .units  (1'b1),
        .busy   (gap_busy),
        .expire (gap_expire)
    );

    wait_timer #(.UW(DLY_W), .LEN(DLY_UNIT)) u_dly (
        .clk    (clk),
        .rst    (rst),
        .load   (dly_load),
        .units  (entry.dly),
        .busy   (dly_busy),
        .expire (dly_expire)
    );

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sel_q     <= '0;
            len_q     <= '0;
            idx       <= '0;
            entry     <= '0;
            o_busy    <= LOW;
            o_done    <= LOW;
            o_send    <= LOW;
            o_data    <= '0;
            o_dc      <= HIGH;
            o_cs      <= HIGH;
            o_rd_addr <= '0;
        end else begin
            o_done <= LOW;
            if (state != S_IDLE && i_abort) begin
                // Abort wins over any handshake or timer event in the same cycle.
                state  <= S_IDLE;
                o_busy <= LOW;
                o_send <= LOW;
                o_data <= DW'(NO_DATA);
                o_dc   <= HIGH;
                o_cs   <= HIGH;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            sel_q  <= i_sel;
                            len_q  <= (i_len > AW'(DEPTH)) ? AW'(DEPTH) : i_len;
                            idx    <= '0;
                            o_busy <= HIGH;
                            if (i_len == '0) begin
                                state  <= S_DONE;
                                o_done <= HIGH;
                                o_cs   <= HIGH;
                            end else begin
                                state     <= S_FETCH;
                                o_rd_addr <= {i_sel, IW'(0)};
                            end
                        end
                    end
                    S_FETCH: state <= S_LOAD;
                    S_LOAD: begin
                        entry  <= rd_entry;
                        o_send <= HIGH;
                        o_data <= rd_entry.data;
                        o_dc   <= rd_entry.dc;
                        o_cs   <= rd_entry.cs;
                        state  <= S_SEND;
                    end
                    S_SEND: begin
                        o_data <= entry.data;
                        if (i_sent) begin
                            state  <= S_GAP;
                            o_send <= LOW;
                            o_data <= DW'(NO_DATA);
                            o_dc   <= entry.dc;
                            o_cs   <= entry.cs;
                        end
                    end
                    S_GAP: begin
                        if (gap_done) begin
                            if (entry.dly != '0) begin
                                state <= S_DELAY;
                                o_cs  <= HIGH;
                                o_dc  <= HIGH;
                            end else begin
                                state <= S_NEXT;
                            end
                        end
                    end
                    S_DELAY: if (dly_done) state <= S_NEXT;
                    S_NEXT: begin
                        if (AW'(idx) == len_q - AW'(1)) begin
                            state  <= S_DONE;
                            o_done <= HIGH;
                            o_cs   <= HIGH;
                        end else begin
                            idx       <= idx + IW'(1);
                            o_rd_addr <= {sel_q, idx + IW'(1)};
                            state     <= S_FETCH;
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        o_busy <= LOW;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
